// File: rtl/uart_rx_pkg.sv
// Shared encodings for the UART receive frame checker: parity modes, FSM states
// and the default data width.
package uart_rx_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Parity bit the line should carry, given the mode and the running XOR of the data.
  function automatic logic exp_parity(input logic [1:0] typ, input logic acc);
    case (typ)
      PAR_EVEN: exp_parity = acc;
      PAR_ODD:  exp_parity = ~acc;
      PAR_MARK: exp_parity = 1'b1;
      default:  exp_parity = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_err_cnt.sv
// Saturating event counter; a clear coinciding with an increment leaves the count at 1.
module uart_err_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = CNT_W'(inc);
    else if (inc && (count_q != {CNT_W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/uart_rx_frame_chk.sv
// UART receive frame checker: deserialises LSB-first data, checks parity and stop
// bits, and reports the word with per-frame error pulses and saturating counters.
module uart_rx_frame_chk
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              frame_start,
  input  logic              bit_vld,
  input  logic              sampled_bit,
  input  logic              par_en,
  input  logic [1:0]        par_typ,
  input  logic              stop2,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rx_data,
  output logic              data_vld,
  output logic              par_err,
  output logic              stp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  par_err_cnt,
  output logic [CNT_W-1:0]  stp_err_cnt
);

  localparam int BC_W = 4;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_acc_q, par_acc_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                par_en_q, par_en_d;
  logic [1:0]          par_typ_q, par_typ_d;
  logic                stop2_q, stop2_d;
  logic                par_flag_q, par_flag_d;
  logic                stp_flag_q, stp_flag_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                data_vld_q, data_vld_d;
  logic                par_err_q, par_err_d;
  logic                stp_err_q, stp_err_d;

  logic last_data, last_stop;
  assign last_data = (bit_cnt_q == BC_W'(DATA_W - 1));
  assign last_stop = stop2_q ? (bit_cnt_q == BC_W'(1)) : 1'b1;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (frame_start) state_d = ST_DATA;
      ST_DATA:   if (bit_vld && last_data) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_vld) state_d = ST_STOP;
      ST_STOP:   if (bit_vld && last_stop) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    bit_cnt_d  = bit_cnt_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;
    par_flag_d = par_flag_q;
    stp_flag_d = stp_flag_q;
    case (state_q)
      ST_IDLE: if (frame_start) begin
        // Config is frozen here; the line settings may change freely mid-frame.
        par_en_d   = par_en;
        par_typ_d  = par_typ;
        stop2_d    = stop2;
        bit_cnt_d  = '0;
        par_acc_d  = 1'b0;
        par_flag_d = 1'b0;
        stp_flag_d = 1'b0;
      end
      ST_DATA: if (bit_vld) begin
        shift_d   = {sampled_bit, shift_q[DATA_W-1:1]};
        par_acc_d = par_acc_q ^ sampled_bit;
        bit_cnt_d = last_data ? '0 : bit_cnt_q + 1'b1;
      end
      ST_PARITY: if (bit_vld)
        par_flag_d = (sampled_bit != exp_parity(par_typ_q, par_acc_q));
      ST_STOP: if (bit_vld) begin
        stp_flag_d = stp_flag_q | ~sampled_bit;
        bit_cnt_d  = last_stop ? '0 : bit_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    data_vld_d = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;
    if (state_q == ST_DONE) begin
      rx_data_d  = shift_q;
      data_vld_d = 1'b1;
      par_err_d  = par_flag_q;
      stp_err_d  = stp_flag_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 2'b00;
      stop2_q    <= 1'b0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
      rx_data_q  <= '0;
      data_vld_q <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
      par_flag_q <= par_flag_d;
      stp_flag_q <= stp_flag_d;
      rx_data_q  <= rx_data_d;
      data_vld_q <= data_vld_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  uart_err_cnt #(.CNT_W(CNT_W)) u_par_cnt (
    .Clk(Clk), .Rst(Rst), .inc(par_err_q), .clr(err_clr), .count(par_err_cnt)
  );

  uart_err_cnt #(.CNT_W(CNT_W)) u_stp_cnt (
    .Clk(Clk), .Rst(Rst), .inc(stp_err_q), .clr(err_clr), .count(stp_err_cnt)
  );

  assign rx_data  = rx_data_q;
  assign data_vld = data_vld_q;
  assign par_err  = par_err_q;
  assign stp_err  = stp_err_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Directed bench for uart_rx_frame_chk: an 8-bit and a 5-bit instance share config
// and line inputs; use_b steers the frame strobes to one of them.
module tb_uart_rx_frame_chk;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       bit_vld = 1'b0;
  logic       sampled_bit = 1'b0;
  logic       par_en = 1'b0;
  logic [1:0] par_typ = 2'b00;
  logic       stop2 = 1'b0;
  logic       err_clr = 1'b0;
  logic       use_b = 1'b0;

  logic       fs_a, bv_a, fs_b, bv_b;
  logic [7:0] rx_a, pcnt_a, scnt_a, pcnt_b, scnt_b;
  logic [4:0] rx_b;
  logic       vld_a, pe_a, se_a, busy_a, vld_b, pe_b, se_b, busy_b;

  logic [8:0] obs_rx;
  logic       obs_vld, obs_pe, obs_se, obs_busy;

  int errors = 0;
  int checks = 0;

  assign fs_a = frame_start & ~use_b;
  assign bv_a = bit_vld & ~use_b;
  assign fs_b = frame_start & use_b;
  assign bv_b = bit_vld & use_b;

  assign obs_rx   = use_b ? {4'b0, rx_b} : {1'b0, rx_a};
  assign obs_vld  = use_b ? vld_b  : vld_a;
  assign obs_pe   = use_b ? pe_b   : pe_a;
  assign obs_se   = use_b ? se_b   : se_a;
  assign obs_busy = use_b ? busy_b : busy_a;

  always #5 Clk = ~Clk;

  uart_rx_frame_chk #(.DATA_W(8), .CNT_W(8)) dut_a (
    .Clk(Clk), .Rst(Rst), .frame_start(fs_a), .bit_vld(bv_a), .sampled_bit(sampled_bit),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .err_clr(err_clr),
    .rx_data(rx_a), .data_vld(vld_a), .par_err(pe_a), .stp_err(se_a), .busy(busy_a),
    .par_err_cnt(pcnt_a), .stp_err_cnt(scnt_a)
  );

  uart_rx_frame_chk #(.DATA_W(5), .CNT_W(8)) dut_b (
    .Clk(Clk), .Rst(Rst), .frame_start(fs_b), .bit_vld(bv_b), .sampled_bit(sampled_bit),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .err_clr(err_clr),
    .rx_data(rx_b), .data_vld(vld_b), .par_err(pe_b), .stp_err(se_b), .busy(busy_b),
    .par_err_cnt(pcnt_b), .stp_err_cnt(scnt_b)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    tick();
    bit_vld = 1'b1;
    sampled_bit = b;
    tick();
    bit_vld = 1'b0;
  endtask

  // Drives one full frame and checks latency, word and flags; returns one cycle
  // after the data_vld pulse, when the counters have absorbed it.
  task automatic run_frame(input string name, input logic [8:0] data, input int nbits,
                           input logic pen, input logic [1:0] ptyp, input logic pbit,
                           input logic s2, input logic [1:0] stops,
                           input logic exp_pe, input logic exp_se,
                           input logic bit_with_start, input logic glitch,
                           input logic clr_at_vld);
    par_en = pen;
    par_typ = ptyp;
    stop2 = s2;
    frame_start = 1'b1;
    if (bit_with_start) begin
      bit_vld = 1'b1;
      sampled_bit = 1'b1;
    end
    tick();
    frame_start = 1'b0;
    bit_vld = 1'b0;
    par_en = ~pen;
    par_typ = ~ptyp;
    stop2 = ~s2;
    checks++;
    if (obs_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: got %b want 1", name, obs_busy);
    end
    for (int i = 0; i < nbits; i++) begin
      send_bit(data[i]);
      if (glitch && i == 3) begin
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
      end
    end
    if (pen) send_bit(pbit);
    send_bit(stops[0]);
    if (s2) send_bit(stops[1]);
    checks++;
    if (obs_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s early_vld: got %b want 0", name, obs_vld);
    end
    tick();
    err_clr = clr_at_vld;
    checks++;
    if (obs_vld !== 1'b1) begin
      errors++;
      $display("FAIL %s data_vld: got %b want 1", name, obs_vld);
    end
    checks++;
    if (obs_rx !== data) begin
      errors++;
      $display("FAIL %s rx_data: got %h want %h", name, obs_rx, data);
    end
    checks++;
    if (obs_pe !== exp_pe) begin
      errors++;
      $display("FAIL %s par_err: got %b want %b", name, obs_pe, exp_pe);
    end
    checks++;
    if (obs_se !== exp_se) begin
      errors++;
      $display("FAIL %s stp_err: got %b want %b", name, obs_se, exp_se);
    end
    tick();
    err_clr = 1'b0;
    checks++;
    if (obs_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s vld_width: got %b want 0", name, obs_vld);
    end
  endtask

  task automatic check_cnts(input string name, input logic [7:0] exp_p, input logic [7:0] exp_s);
    checks++;
    if (pcnt_a !== exp_p) begin
      errors++;
      $display("FAIL %s par_err_cnt: got %0d want %0d", name, pcnt_a, exp_p);
    end
    checks++;
    if (scnt_a !== exp_s) begin
      errors++;
      $display("FAIL %s stp_err_cnt: got %0d want %0d", name, scnt_a, exp_s);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({rx_a, vld_a, pe_a, se_a, busy_a, pcnt_a, scnt_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b%b%b%b/%0d/%0d want all 0",
               rx_a, vld_a, pe_a, se_a, busy_a, pcnt_a, scnt_a);
    end
    tick();
    Rst = 1'b1;
    tick();
  endtask

  task automatic test_even();
    run_frame("even_a5", 9'h0A5, 8, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_cnts("even_a5", 8'd0, 8'd0);
  endtask

  task automatic test_odd_saturate();
    run_frame("odd_a5", 9'h0A5, 8, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_cnts("odd_a5", 8'd1, 8'd0);
    for (int n = 0; n < 254; n++)
      run_frame("odd_rep", 9'h0A5, 8, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_cnts("odd_255", 8'd255, 8'd0);
    run_frame("odd_sat", 9'h0A5, 8, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_cnts("odd_sat", 8'd255, 8'd0);
  endtask

  task automatic test_stop2();
    run_frame("stop2_3c", 9'h03C, 8, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_cnts("stop2_3c", 8'd255, 8'd1);
  endtask

  task automatic test_mark_space();
    run_frame("mark", 9'h001, 8, 1'b1, 2'b10, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("space", 9'h001, 8, 1'b1, 2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_midframe();
    run_frame("midframe", 9'h0A5, 8, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_start_with_bit();
    run_frame("start_bit", 9'h000, 8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_clr_coincident();
    run_frame("clr_inc", 9'h0A5, 8, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_cnts("clr_inc", 8'd1, 8'd0);
  endtask

  task automatic test_width5();
    use_b = 1'b1;
    run_frame("w5_15", 9'h015, 5, 1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    use_b = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic seen_vld;
    par_en = 1'b1;
    par_typ = 2'b00;
    stop2 = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    #2;
    Rst = 1'b0;
    #1;
    checks++;
    if ({rx_a, vld_a, pe_a, se_a, busy_a, pcnt_a, scnt_a} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h/%b%b%b%b/%0d/%0d want all 0",
               rx_a, vld_a, pe_a, se_a, busy_a, pcnt_a, scnt_a);
    end
    #2;
    Rst = 1'b1;
    seen_vld = 1'b0;
    bit_vld = 1'b1;
    sampled_bit = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (vld_a !== 1'b0) seen_vld = 1'b1;
    end
    bit_vld = 1'b0;
    checks++;
    if (seen_vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_vld: got data_vld=1 want 0");
    end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd_saturate();
    test_stop2();
    test_mark_space();
    test_midframe();
    test_start_with_bit();
    test_clr_coincident();
    test_width5();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_chk.md
Name: uart_rx_frame_chk

Overview:
Parametrised serial frame checker for the UART receive path; successor to the single-width parity checker.
- Consumes sampled bits from the oversampling/edge logic after the start bit is confirmed.
- Deserialises the data LSB-first and accumulates running parity serially.
- Checks the parity bit (four parity modes) and one or two stop bits.
- Outputs the received word with per-frame error flags, plus saturating error counters for the status block.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9
CNT_W, 8, width of each saturating error counter

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse: start bit confirmed, next bit_vld is data bit 0
bit_vld  in  1  one-cycle strobe: sampled_bit is valid this cycle
sampled_bit  in  1  mid-bit sampled RX value
par_en  in  1  1 = parity bit present in frame
par_typ  in  2  00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0)
stop2  in  1  1 = two stop bits expected
err_clr  in  1  one-cycle pulse: clear both error counters
rx_data  out  DATA_W  last completed word, held until next completion
data_vld  out  1  one-cycle pulse: frame complete
par_err  out  1  one-cycle pulse coincident with data_vld: parity mismatch
stp_err  out  1  one-cycle pulse coincident with data_vld: any stop bit sampled 0
busy  out  1  high while not IDLE
par_err_cnt  out  CNT_W  saturating count of par_err pulses
stp_err_cnt  out  CNT_W  saturating count of stp_err pulses

Behaviour:
- Clock and reset: single clock Clk; Rst asynchronous, active-low. On reset all outputs are 0, the FSM is in IDLE, the shift register, parity accumulator and bit counter are 0, and latched config is 0.
- Config capture: par_en, par_typ and stop2 are latched on the frame_start cycle (IDLE only). Config changes mid-frame have no effect.
- FSM states: IDLE, DATA, PARITY, STOP, DONE.
  - IDLE: frame_start -> DATA. Clears the bit counter and sets running parity to 0.
  - DATA: each bit_vld shifts sampled_bit into the shift register MSB-side (LSB-first frame) and XORs it into the running parity. After DATA_W bits: -> PARITY if par_en, else -> STOP.
  - PARITY: on bit_vld compare sampled_bit with the expected bit and latch the mismatch; -> STOP.
    - even: expected = running XOR.
    - odd: expected = ~running XOR.
    - mark: expected = 1.
    - space: expected = 0.
  - STOP: each bit_vld ORs ~sampled_bit into the stop-error flag. After 1 stop bit (stop2=0) or 2 stop bits (stop2=1) -> DONE.
  - DONE: one cycle.
    - rx_data loads the shift register.
    - data_vld=1, with par_err/stp_err driven from the latched flags.
    - -> IDLE.
- Latency: data_vld rises exactly 2 cycles after the bit_vld of the final stop bit (STOP->DONE register, then output register).
- Outputs on error: rx_data and data_vld are produced even when errors are flagged. No frame is ever dropped once started.
- Strobe handling: bit_vld in IDLE or DONE is ignored. frame_start outside IDLE is ignored; the frame in progress completes.
- frame_start and bit_vld in the same cycle in IDLE: frame_start is taken; that bit_vld is ignored.
- par_err is 0 whenever par_en was 0 at frame start.
- Counters:
  - Increment on the par_err/stp_err output pulse.
  - Saturate at 2^CNT_W-1; no wrap.
  - err_clr sets both counters to 0. If err_clr coincides with an increment, the result is 1 (clear, then count).
- Reset mid-frame: immediate return to IDLE with all state cleared. No data_vld is produced for the aborted frame.

Decomposition:
- Package uart_rx_pkg holds:
  - par_typ encodings: PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11.
  - FSM state encoding constants.
  - Default DATA_W.
- Sub-module uart_err_cnt (parameter CNT_W; inputs inc, clr; output saturating count), instantiated twice.

Test Plan:
- Even parity, 1 stop, DATA_W=8: frame_start, bits of 0xA5 LSB-first, parity 0, stop 1 -> rx_data=0xA5, data_vld pulse 2 cycles after stop strobe, par_err=0, stp_err=0.
- Odd parity, same data 0xA5 with parity bit 0 -> par_err=1 with data_vld, par_err_cnt=1; repeat 255 more times with CNT_W=8 -> counter holds 255.
- par_en=0, stop2=1: data 0x3C, stops 1 then 0 -> stp_err=1, par_err=0, rx_data=0x3C, stp_err_cnt increments.
- Mark/space: par_typ=10 with parity bit 0 -> par_err=1; par_typ=11 with parity bit 0 -> par_err=0. DATA_W=5 build: data 0x15 received correctly in 5 bits.
- frame_start pulses mid-DATA and par_typ toggled mid-frame -> ignored; the frame completes with the config latched at start.
- Rst asserted during PARITY -> all outputs 0 immediately, no data_vld. err_clr coincident with a par_err pulse -> par_err_cnt=1.
